pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64; datapath payload width (e.g. BusA and BusB), never cleared on bubble.
REQ-002 SHALL have parameter CTRL_W, default 3; control payload width (e.g. MemWr/MemRd/RegWr), forced to zero whenever the stage holds a bubble.
REQ-003 SHALL have port clk, input, 1; the single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port flush, input, 1; kills all stage contents and the current input beat.
REQ-006 SHALL have port in_valid, input, 1; the upstream beat is present.
REQ-007 SHALL have port in_ready, output, 1; the stage accepts the beat this cycle.
REQ-008 SHALL have port in_ctrl, input, CTRL_W; upstream control field.
REQ-009 SHALL have port in_data, input, DATA_W; upstream data field.
REQ-010 SHALL have port out_valid, output, 1; the downstream beat is present.
REQ-011 SHALL have port out_ready, input, 1; downstream consumes the beat this cycle (deasserted = stall).
REQ-012 SHALL have port out_ctrl, output, CTRL_W; downstream control field.
REQ-013 SHALL have port out_data, output, DATA_W; downstream data field.
REQ-014 SHALL have port occupancy, output, 2; beats held: 0, 1 or 2.

Function
REQ-015 SHALL accept a beat when in_valid and in_ready are both high, and transfer a beat out when out_valid and out_ready are both high.
REQ-016 SHALL have a latency of exactly 1 cycle from acceptance into an empty stage to out_valid high.
REQ-017 SHALL drive out_ctrl to all-zero whenever out_valid is low.
REQ-018 SHALL leave out_data holding its last value when out_valid is low.
REQ-019 SHALL have three states: EMPTY (occupancy 0), FULL (occupancy 1) and SKID (occupancy 2, with the second beat in the skid register).
REQ-020 SHALL go EMPTY->FULL on accept.
REQ-021 SHALL go FULL->EMPTY on transfer without accept.
REQ-022 SHALL stay FULL when accept and transfer occur together, and SHALL load the new beat.
REQ-023 SHALL go FULL->SKID on accept without transfer.
REQ-024 SHALL go SKID->FULL on transfer, with the skid beat moving to the output register.
REQ-025 SHALL drive in_ready high when the state is not SKID; in_ready SHALL be a register output with no combinational path from out_ready.
REQ-026 SHALL preserve beat order; no beat SHALL be duplicated or dropped except by flush.
REQ-027 SHALL, on flush, go EMPTY with occupancy 0 on the next cycle and discard any beat accepted in the flush cycle.
REQ-028 SHALL treat a transfer that occurs in the flush cycle as completed.
REQ-029 SHALL, when reset and flush are asserted together, behave as reset.

Reset
REQ-030 SHALL, on reset, set the state to EMPTY, out_valid 0, out_ctrl 0, out_data 0, the skid register 0, occupancy 0 and in_ready 1 on the following cycle.
REQ-031 SHALL, on reset in any state, discard all held beats with no output transfer reported afterwards.

Configuration
REQ-032 SHALL include the skid register and the SKID state when macro PIPE_STAGE_SKID_EN is defined, behaving as REQ-019 to REQ-025.
REQ-033 SHALL, without PIPE_STAGE_SKID_EN, implement the EMPTY and FULL states only.
REQ-034 SHALL, without PIPE_STAGE_SKID_EN, drive in_ready = !out_valid || out_ready combinationally and limit occupancy to at most 1.
REQ-035 SHALL keep all other requirements identical with and without PIPE_STAGE_SKID_EN.

Structure
REQ-036 SHALL take the state encoding (EMPTY/FULL/SKID) and the default widths from the shared pipeline package.
REQ-037 SHALL instantiate one sub-module, pipe_payload_reg: a DATA_W+CTRL_W register with load enable and ctrl clear, used for the output register and the skid register.

Verification
REQ-038 SHALL verify single beat: reset, then in_ctrl=3'b101, in_data=64'hA5 with out_ready=1 -> one cycle later out_valid=1, out_ctrl=3'b101, out_data=64'hA5, then out_valid=0 and out_ctrl=0.
REQ-039 SHALL verify stall: out_ready=0 while beats 1, 2, 3 are offered -> occupancy=2 and in_ready=0 (skid build); after out_ready=1, beats come out as 1, 2, 3 in consecutive cycles.
REQ-040 SHALL verify streaming: in_valid=1 and out_ready=1 for 8 cycles with data 0..7 -> out_data 0..7 one per cycle, occupancy stays 1.
REQ-041 SHALL verify flush: flush asserted at occupancy 2 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and the flushed beats never appear.
REQ-042 SHALL verify reset mid-stream: reset at occupancy 1 together with flush -> out_valid=0, out_data=0, in_ready=1 on the following cycle.
REQ-043 SHALL verify the build without PIPE_STAGE_SKID_EN: out_ready=0 and a beat held -> in_ready=0 in the same cycle; occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline package: stage state encoding and default payload widths.
// The state value doubles as the stage occupancy count.
package pipe_stage_reg_pkg;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_payload.sv
// Payload register (data + control) with load enable and control clear.
// A clear wipes only the control field; data keeps its last value.
module pipe_payload_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  logic [CTRL_W-1:0] ctrl_p1;
  logic [DATA_W-1:0] data_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_p1 <= '0;
      data_p1 <= '0;
    end else begin
      if (load)
        data_p1 <= d_data;
      if (clr_ctrl)
        ctrl_p1 <= '0;
      else if (load)
        ctrl_p1 <= d_ctrl;
    end
  end

  assign q_ctrl = ctrl_p1;
  assign q_data = data_p1;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with bubble-cleared control field.
// Define PIPE_STAGE_SKID_EN for a registered in_ready backed by a skid register.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  stage_state_e      state;
  logic              accept;
  logic              xfer;
  logic              load_out;
  logic              clr_out;
  logic [CTRL_W-1:0] out_d_ctrl;
  logic [DATA_W-1:0] out_d_data;

  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state;

`ifdef PIPE_STAGE_SKID_EN
  logic              in_ready_q;
  logic              load_skid;
  logic              clr_skid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // in_ready comes straight from a flop, so out_ready never reaches it
  assign in_ready = in_ready_q;

  always_comb begin
    load_out  = 1'b0;
    clr_out   = flush;
    load_skid = 1'b0;
    clr_skid  = flush;
    if (!flush) begin
      case (state)
        ST_EMPTY: load_out = accept;
        ST_FULL: begin
          load_out  = accept && xfer;
          load_skid = accept && !xfer;
          clr_out   = xfer && !accept;
        end
        ST_SKID: begin
          load_out = xfer;
          clr_skid = xfer;
        end
        default: clr_out = 1'b1;
      endcase
    end
  end

  assign out_d_ctrl = (state == ST_SKID) ? skid_ctrl : in_ctrl;
  assign out_d_data = (state == ST_SKID) ? skid_data : in_data;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY:
          if (accept) state <= ST_FULL;
        ST_FULL:
          if (accept && !xfer) begin
            state      <= ST_SKID;
            in_ready_q <= 1'b0;
          end else if (!accept && xfer) begin
            state <= ST_EMPTY;
          end
        ST_SKID:
          if (xfer) begin
            state      <= ST_FULL;
            in_ready_q <= 1'b1;
          end
        default: begin
          state      <= ST_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  pipe_payload_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_skid_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (load_skid),
    .clr_ctrl(clr_skid),
    .d_ctrl  (in_ctrl),
    .d_data  (in_data),
    .q_ctrl  (skid_ctrl),
    .q_data  (skid_data)
  );
`else
  // Without a skid register the stage can only take a beat when the held one leaves
  assign in_ready   = !out_valid || out_ready;
  assign load_out   = !flush && accept;
  assign clr_out    = flush || (xfer && !accept);
  assign out_d_ctrl = in_ctrl;
  assign out_d_data = in_data;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= ST_EMPTY;
    end else if (accept) begin
      state <= ST_FULL;
    end else if (xfer) begin
      state <= ST_EMPTY;
    end
  end
`endif

  pipe_payload_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (load_out),
    .clr_ctrl(clr_out),
    .d_ctrl  (out_d_ctrl),
    .d_data  (out_d_data),
    .q_ctrl  (out_ctrl),
    .q_data  (out_data)
  );

endmodule
